traffic_light_monitor: RTL and testbench

//  Passive consumer of a red/yellow/green lamp triple from a traffic light controller.

---
 rtl/tl_pkg.sv | 21 ++
 rtl/tl_phase_decode.sv | 35 +++
 rtl/traffic_light_monitor.sv | 138 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - phase encodings and successor order shared with the light controller
package tl_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    // Legal lamp sequence is R -> G -> Y -> R; SYNC has no successor.
    function automatic phase_t successor(input phase_t p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// rtl/tl_phase_decode.sv - lamp input register, one-hot check and phase encode
module tl_phase_decode
    import tl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   red,
    input  logic   yellow,
    input  logic   green,
    output phase_t code,
    output logic   valid
);

    logic [2:0] lamps;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamps <= 3'b000;
        end else begin
            lamps <= {red, yellow, green};
        end
    end

    always_comb begin
        code  = PH_SYNC;
        valid = 1'b0;
        case (lamps)
            3'b100: begin code = PH_RED;    valid = 1'b1; end
            3'b001: begin code = PH_GREEN;  valid = 1'b1; end
            3'b010: begin code = PH_YELLOW; valid = 1'b1; end
            default: begin code = PH_SYNC;  valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - phase FSM, phase timing, sticky errors, walk and cycle count
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int RED_MIN    = 8,
    parameter int RED_MAX    = 10,
    parameter int GREEN_MIN  = 6,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 3,
    parameter int WALK_START = 1,
    parameter int WALK_END   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clear,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             walk,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_short,
    output logic             err_long,
    output logic             err_any,
    output logic [15:0]      cycles_done
);

    phase_t           code;
    logic             valid;
    phase_t           state;
    phase_t           nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_walk;
    logic             ev_onehot;
    logic             ev_order;
    logic             ev_short;
    logic             ev_long;
    logic             cyc_inc;

    tl_phase_decode u_decode (
        .clk    (clk),
        .rst    (rst),
        .red    (red),
        .yellow (yellow),
        .green  (green),
        .code   (code),
        .valid  (valid)
    );

    function automatic logic [CNT_W-1:0] min_len(input phase_t p);
        case (p)
            PH_RED:    return CNT_W'(RED_MIN);
            PH_GREEN:  return CNT_W'(GREEN_MIN);
            PH_YELLOW: return CNT_W'(YELLOW_MIN);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] max_len(input phase_t p);
        case (p)
            PH_RED:    return CNT_W'(RED_MAX);
            PH_GREEN:  return CNT_W'(GREEN_MAX);
            PH_YELLOW: return CNT_W'(YELLOW_MAX);
            default:   return '1;
        endcase
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_cnt   = phase_cnt;
        ev_onehot = 1'b0;
        ev_order  = 1'b0;
        ev_short  = 1'b0;
        ev_long   = 1'b0;
        cyc_inc   = 1'b0;
        if (state == PH_SYNC) begin
            if (valid && code == PH_RED) begin
                nxt_state = PH_RED;
                nxt_cnt   = CNT_W'(1);
            end else begin
                nxt_cnt   = '0;
            end
        end else if (!valid) begin
            ev_onehot = 1'b1;
            nxt_state = PH_SYNC;
            nxt_cnt   = '0;
        end else if (code == state) begin
            // err_long fires only on the MAX -> MAX+1 step, not every cycle after
            ev_long = (phase_cnt == max_len(state));
            if (phase_cnt != '1) begin
                nxt_cnt = phase_cnt + 1'b1;
            end
        end else if (code == successor(state)) begin
            ev_short  = (phase_cnt < min_len(state));
            cyc_inc   = (state == PH_YELLOW);
            nxt_state = code;
            nxt_cnt   = CNT_W'(1);
        end else begin
            ev_order  = 1'b1;
            nxt_state = code;
            nxt_cnt   = CNT_W'(1);
        end
        nxt_walk = (nxt_state == PH_RED) &&
                   (nxt_cnt >= CNT_W'(WALK_START)) &&
                   (nxt_cnt <= CNT_W'(WALK_END));
    end

    // A flag event in the same cycle as clear still sets the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= PH_SYNC;
            phase_cnt   <= '0;
            walk        <= 1'b0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            cycles_done <= 16'd0;
        end else begin
            state       <= nxt_state;
            phase_cnt   <= nxt_cnt;
            walk        <= nxt_walk;
            err_onehot  <= (err_onehot & ~clear) | ev_onehot;
            err_order   <= (err_order  & ~clear) | ev_order;
            err_short   <= (err_short  & ~clear) | ev_short;
            err_long    <= (err_long   & ~clear) | ev_long;
            cycles_done <= cycles_done + {15'd0, cyc_inc};
        end
    end

    assign phase   = state;
    assign err_any = err_onehot | err_order | err_short | err_long;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] RG = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        red;
    logic        yellow;
    logic        green;
    logic        clear;
    logic [1:0]  phase;
    logic [7:0]  phase_cnt;
    logic        walk;
    logic        err_onehot;
    logic        err_order;
    logic        err_short;
    logic        err_long;
    logic        err_any;
    logic [15:0] cycles_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    logic [2:0]  m_lamp;
    int          m_state;
    int          m_cnt;
    logic        m_walk;
    logic [3:0]  m_err;
    logic [15:0] m_cyc;

    wire [31:0] obs = {phase, phase_cnt, walk, err_onehot, err_order, err_short,
                       err_long, err_any, cycles_done};

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .clear       (clear),
        .phase       (phase),
        .phase_cnt   (phase_cnt),
        .walk        (walk),
        .err_onehot  (err_onehot),
        .err_order   (err_order),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_any     (err_any),
        .cycles_done (cycles_done)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_lamp  = 3'b000;
        m_state = 0;
        m_cnt   = 0;
        m_walk  = 1'b0;
        m_err   = 4'b0000;
        m_cyc   = 16'd0;
    endtask

    // m_err bits: [3] onehot, [2] order, [1] short, [0] long
    task automatic model_edge(input logic [2:0] pins, input logic c);
        int lp;
        int mn;
        int mx;
        if (c) m_err = 4'b0000;
        case (m_lamp)
            3'b100:  lp = 1;
            3'b001:  lp = 2;
            3'b010:  lp = 3;
            default: lp = 0;
        endcase
        mn = (m_state == 1) ? 8  : (m_state == 2) ? 6 : 2;
        mx = (m_state == 1) ? 10 : (m_state == 2) ? 8 : 3;
        if (m_state == 0) begin
            if (lp == 1) begin
                m_state = 1;
                m_cnt   = 1;
            end else begin
                m_cnt   = 0;
            end
        end else if (lp == 0) begin
            m_err[3] = 1'b1;
            m_state  = 0;
            m_cnt    = 0;
        end else if (lp == m_state) begin
            if (m_cnt == mx) m_err[0] = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end else if (lp == (m_state % 3) + 1) begin
            if (m_cnt < mn) m_err[1] = 1'b1;
            if (m_state == 3) m_cyc++;
            m_state = lp;
            m_cnt   = 1;
        end else begin
            m_err[2] = 1'b1;
            m_state  = lp;
            m_cnt    = 1;
        end
        m_walk = (m_state == 1) && (m_cnt >= 1) && (m_cnt <= 5);
        m_lamp = pins;
    endtask

    function automatic logic [31:0] model_vec();
        return {m_state[1:0], m_cnt[7:0], m_walk, m_err, |m_err, m_cyc};
    endfunction

    task automatic step(input logic [2:0] ryg, input logic c);
        {red, yellow, green} = ryg;
        clear = c;
        model_edge(ryg, c);
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
        chk("scoreboard", obs, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] ryg, input int n);
        repeat (n) step(ryg, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        {red, yellow, green} = 3'b000;
        clear = 1'b0;
        model_reset();
        repeat (9) @(negedge clk);
        chk("reset_state", obs, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run(R, 9);
            step(G, 1'b0);
            chk("red_peak", {21'd0, phase, phase_cnt, walk}, {21'd0, 2'd1, 8'd9, 1'b0});
            run(G, 6);
            step(Y, 1'b0);
            chk("green_peak", {21'd0, phase, phase_cnt, walk}, {21'd0, 2'd2, 8'd7, 1'b0});
            run(Y, 2);
        end

        step(R, 1'b0);
        chk("yellow_peak", {21'd0, phase, phase_cnt, walk}, {21'd0, 2'd3, 8'd3, 1'b0});
        step(R, 1'b0);
        chk("cycles_after_3", {16'd0, cycles_done}, 32'd3);
        run(R, 9);
        chk("long_not_yet", {23'd0, phase_cnt, err_long}, {23'd0, 8'd10, 1'b0});
        step(R, 1'b0);
        chk("long_set", {23'd0, phase_cnt, err_long}, {23'd0, 8'd11, 1'b1});
        run(G, 7);
        chk("long_sticky", {30'd0, phase, err_long} , {30'd0, 2'd2, 1'b1} );
        step(G, 1'b1);
        chk("long_cleared", {30'd0, err_long, err_any}, 32'd0);
        run(Y, 3);

        run(R, 9);
        run(G, 4);
        step(Y, 1'b0);
        step(Y, 1'b0);
        chk("short", {21'd0, phase, phase_cnt, err_short}, {21'd0, 2'd3, 8'd1, 1'b1});
        step(Y, 1'b0);

        step(R, 1'b1);
        run(R, 8);
        step(Y, 1'b0);
        step(Y, 1'b0);
        chk("order", {5'd0, phase, phase_cnt, err_order, cycles_done},
            {5'd0, 2'd3, 8'd1, 1'b1, 16'd5});
        step(Y, 1'b0);

        step(R, 1'b1);
        run(R, 2);
        step(RG, 1'b0);
        step(R, 1'b0);
        chk("onehot", {29'd0, phase, walk, err_onehot}, {29'd0, 2'd0, 1'b0, 1'b1});
        step(R, 1'b0);
        chk("resync", {22'd0, phase, phase_cnt}, {22'd0, 2'd1, 8'd1});

        run(R, 8);
        run(G, 3);
        step(Y, 1'b0);
        step(Y, 1'b1);
        chk("clear_vs_short", {30'd0, err_onehot, err_short}, {30'd0, 1'b0, 1'b1});
        step(Y, 1'b0);

        run(R, 9);
        run(G, 3);
        rst = 1'b0;
        #1;
        chk("async_reset", obs, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(R, 4);
        chk("post_reset_red", {22'd0, phase, phase_cnt}, {22'd0, 2'd1, 8'd3});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
